// File: rtl/io_param_fifo_if.sv
// Stream handshake bundle for io_param_fifo: producer side (valid_i/data_i/ready_o)
// and consumer side (valid_o/data_o/ready_i), named from the FIFO's point of view.
interface io_param_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  ready_o;
    logic                  valid_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  ready_i;

    modport slave (
        input  valid_i,
        input  data_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o
    );

    modport master (
        output valid_i,
        output data_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o
    );
endinterface

// File: rtl/io_param_fifo.sv
// Parametrised IO FIFO with arbitrary depth, optional fall-through, watermarks,
// free-slot count and sticky overflow; clr_i flushes synchronously.
module io_param_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = $clog2(DEPTH + 1),
    parameter bit FALL_THROUGH = 1'b0,
    parameter int AFULL_LVL    = DEPTH - 1,
    parameter int AEMPTY_LVL   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    io_param_fifo_if.slave       bus,
    output logic [CNT_W-1:0]     elements_o,
    output logic [CNT_W-1:0]     free_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic                 overflow_o
);

    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] AEMPT_CNT = CNT_W'(AEMPTY_LVL);

    // Wrap by explicit compare so non-power-of-two depths index only valid entries.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_IDX) ? {PTR_W{1'b0}} : ptr + PTR_W'(1'b1);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  ovf_q,    ovf_d;

    logic full_s, empty_s, ready_s, valid_s;
    logic push_s, pop_s, bypass_s, wr_en_s, rd_en_s;

    // Handshake decode; a fall-through bypass moves a word without touching storage.
    always_comb begin
        full_s   = (count_q == DEPTH_CNT);
        empty_s  = (count_q == {CNT_W{1'b0}});
        ready_s  = ~full_s & ~clr_i;
        valid_s  = ((FALL_THROUGH != 1'b0) ? (~empty_s | bus.valid_i) : ~empty_s) & ~clr_i;
        push_s   = bus.valid_i & ready_s;
        pop_s    = valid_s & bus.ready_i;
        bypass_s = (FALL_THROUGH != 1'b0) & empty_s & push_s & pop_s;
        wr_en_s  = push_s & ~bypass_s;
        rd_en_s  = pop_s & ~bypass_s;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clr_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            ovf_d    = 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
            if (bus.valid_i & full_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= bus.data_i;
        end
    end

    assign bus.ready_o    = ready_s;
    assign bus.valid_o    = valid_s;
    assign bus.data_o     = ((FALL_THROUGH != 1'b0) && empty_s) ? bus.data_i : mem_q[rd_ptr_q];
    // Watermarks follow the stored count only, never the bypass word.
    assign elements_o     = count_q;
    assign free_o         = DEPTH_CNT - count_q;
    assign almost_full_o  = (count_q >= AFULL_CNT);
    assign almost_empty_o = (count_q <= AEMPT_CNT);
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_io_param_fifo.sv
// Bench for io_param_fifo: a registered-mode DEPTH=3 instance and a fall-through
// DEPTH=5 instance share stimulus and are checked against a queue-style model.
module tb_io_param_fifo;

    logic       clk = 1'b0;
    logic       rst, clr, vin, rin;
    logic [7:0] din;

    always #5 clk = ~clk;

    io_param_fifo_if #(.DATA_WIDTH(8)) bus0 ();
    io_param_fifo_if #(.DATA_WIDTH(8)) bus1 ();

    assign bus0.valid_i = vin;
    assign bus0.data_i  = din;
    assign bus0.ready_i = rin;
    assign bus1.valid_i = vin;
    assign bus1.data_i  = din;
    assign bus1.ready_i = rin;

    logic [1:0] el0, fr0;
    logic [2:0] el1, fr1;
    logic       af0, ae0, ov0, af1, ae1, ov1;

    io_param_fifo #(.DATA_WIDTH(8), .DEPTH(3), .FALL_THROUGH(1'b0),
                    .AFULL_LVL(2), .AEMPTY_LVL(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .bus(bus0),
        .elements_o(el0), .free_o(fr0), .almost_full_o(af0),
        .almost_empty_o(ae0), .overflow_o(ov0));

    io_param_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FALL_THROUGH(1'b1),
                    .AFULL_LVL(4), .AEMPTY_LVL(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .bus(bus1),
        .elements_o(el1), .free_o(fr1), .almost_full_o(af1),
        .almost_empty_o(ae1), .overflow_o(ov1));

    int checks   = 0;
    int failures = 0;

    // Reference model: per instance an ordered list (head at index 0) plus overflow flag.
    int         dep_m [2] = '{3, 5};
    bit         ft_m  [2] = '{1'b0, 1'b1};
    int         af_m  [2] = '{2, 4};
    int         ae_m  [2] = '{1, 1};
    logic [7:0] mdat  [2][8];
    int         mcnt  [2];
    bit         movf  [2];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       c;
        int         elems;
        logic       valid;
        logic [7:0] data;
        logic       rdy;
        logic       afull;
        logic       aempty;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic get_out(input int id, output logic v, output logic r, output logic [7:0] d,
                           output logic [31:0] el, output logic [31:0] fr,
                           output logic af, output logic ae, output logic ov);
        if (id == 0) begin
            v = bus0.valid_o; r = bus0.ready_o; d = bus0.data_o;
            el = 32'(el0); fr = 32'(fr0); af = af0; ae = ae0; ov = ov0;
        end else begin
            v = bus1.valid_o; r = bus1.ready_o; d = bus1.data_o;
            el = 32'(el1); fr = 32'(fr1); af = af1; ae = ae1; ov = ov1;
        end
    endtask

    task automatic check_model(input int id);
        logic v, r, af, ae, ov;
        logic [7:0] d;
        logic [31:0] el, fr;
        bit full, empty, ev, er;
        full  = (mcnt[id] == dep_m[id]);
        empty = (mcnt[id] == 0);
        er    = !full && !clr;
        ev    = (ft_m[id] ? (!empty || vin) : !empty) && !clr;
        get_out(id, v, r, d, el, fr, af, ae, ov);
        chk($sformatf("m%0d_ready", id), 32'(r), 32'(er));
        chk($sformatf("m%0d_valid", id), 32'(v), 32'(ev));
        chk($sformatf("m%0d_elements", id), el, 32'(mcnt[id]));
        chk($sformatf("m%0d_free", id), fr, 32'(dep_m[id] - mcnt[id]));
        chk($sformatf("m%0d_afull", id), 32'(af), 32'(mcnt[id] >= af_m[id]));
        chk($sformatf("m%0d_aempty", id), 32'(ae), 32'(mcnt[id] <= ae_m[id]));
        chk($sformatf("m%0d_overflow", id), 32'(ov), 32'(movf[id]));
        if (ev) begin
            chk($sformatf("m%0d_data", id), 32'(d), 32'(empty ? din : mdat[id][0]));
        end
    endtask

    task automatic update_model(input int id);
        bit full, empty, ev, er, push, pop;
        full  = (mcnt[id] == dep_m[id]);
        empty = (mcnt[id] == 0);
        er    = !full && !clr;
        ev    = (ft_m[id] ? (!empty || vin) : !empty) && !clr;
        push  = vin && er;
        pop   = ev && rin;
        if (clr) begin
            mcnt[id] = 0;
            movf[id] = 1'b0;
        end else begin
            if (vin && full) movf[id] = 1'b1;
            if (!(ft_m[id] && empty && push && pop)) begin
                if (pop) begin
                    for (int k = 0; k < 7; k++) mdat[id][k] = mdat[id][k+1];
                    mcnt[id]--;
                end
                if (push) begin
                    mdat[id][mcnt[id]] = din;
                    mcnt[id]++;
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
        vin = v; din = d; rin = r; clr = c;
        @(negedge clk);
        check_model(0);
        check_model(1);
    endtask

    task automatic tick();
        @(posedge clk);
        update_model(0);
        update_model(1);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; vin = 1'b0; rin = 1'b0; din = 8'h3C;
        mcnt[0] = 0; mcnt[1] = 0; movf[0] = 1'b0; movf[1] = 1'b0;

        tbl[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 8'hA3, 1'b0, 1'b0, 2, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        drive(1'b0, 8'h3C, 1'b0, 1'b0);
        chk("rst_valid0", 32'(bus0.valid_o), 32'd0);
        chk("rst_ready0", 32'(bus0.ready_o), 32'd1);
        chk("rst_elem0", 32'(el0), 32'd0);
        chk("rst_free0", 32'(fr0), 32'd3);
        chk("rst_aempty0", 32'(ae0), 32'd1);
        chk("rst_afull0", 32'(af0), 32'd0);
        chk("rst_ovf0", 32'(ov0), 32'd0);
        chk("rst_free1", 32'(fr1), 32'd5);
        chk("rst_ftdata1", 32'(bus1.data_o), 32'h3C);
        tick();

        // Fill and drain from the vector table
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
            chk($sformatf("t1[%0d]_elems", i), 32'(el0), 32'(tbl[i].elems));
            chk($sformatf("t1[%0d]_valid", i), 32'(bus0.valid_o), 32'(tbl[i].valid));
            chk($sformatf("t1[%0d]_ready", i), 32'(bus0.ready_o), 32'(tbl[i].rdy));
            chk($sformatf("t1[%0d]_afull", i), 32'(af0), 32'(tbl[i].afull));
            chk($sformatf("t1[%0d]_aempty", i), 32'(ae0), 32'(tbl[i].aempty));
            if (tbl[i].valid) chk($sformatf("t1[%0d]_data", i), 32'(bus0.data_o), 32'(tbl[i].data));
            tick();
        end

        // Continuous streaming through a depth-3 ring
        for (int k = 0; k <= 10; k++) begin
            drive(k < 10, 8'(k), 1'b1, 1'b0);
            if (k >= 1) begin
                chk($sformatf("t2[%0d]_data", k), 32'(bus0.data_o), 32'(k - 1));
                chk($sformatf("t2[%0d]_elems", k), 32'(el0), 32'd1);
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();

        // Overflow while full, then flush
        drive(1'b1, 8'hC1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC2, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC3, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("t3_ovf_pre", 32'(ov0), 32'd0);
        tick();
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("t3_ovf_set", 32'(ov0), 32'd1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_ovf_hold", 32'(ov0), 32'd1);
        chk("t3_elems", 32'(el0), 32'd3);
        chk("t3_head", 32'(bus0.data_o), 32'hC1);
        tick();
        drive(1'b1, 8'h77, 1'b1, 1'b1);
        chk("t3_clr_valid", 32'(bus0.valid_o), 32'd0);
        chk("t3_clr_ready", 32'(bus0.ready_o), 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_post_elems", 32'(el0), 32'd0);
        chk("t3_post_ovf", 32'(ov0), 32'd0);
        chk("t3_post_valid", 32'(bus0.valid_o), 32'd0);
        tick();

        // Full with simultaneous push and pop: only the pop happens
        drive(1'b1, 8'hB1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hB2, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hB3, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hB4, 1'b1, 1'b0);
        chk("t4_ready_full", 32'(bus0.ready_o), 32'd0);
        chk("t4_head", 32'(bus0.data_o), 32'hB1);
        tick();
        drive(1'b1, 8'hB5, 1'b0, 1'b0);
        chk("t4_elems", 32'(el0), 32'd2);
        chk("t4_ready", 32'(bus0.ready_o), 32'd1);
        chk("t4_head2", 32'(bus0.data_o), 32'hB2);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_refill", 32'(el0), 32'd3);
        chk("t4_pop_b2", 32'(bus0.data_o), 32'hB2);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_pop_b3", 32'(bus0.data_o), 32'hB3);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_pop_b5", 32'(bus0.data_o), 32'hB5);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();

        // Fall-through bypass on the empty FT instance
        drive(1'b1, 8'h5C, 1'b1, 1'b0);
        chk("t5_bypass_valid", 32'(bus1.valid_o), 32'd1);
        chk("t5_bypass_data", 32'(bus1.data_o), 32'h5C);
        chk("t5_bypass_elems", 32'(el1), 32'd0);
        tick();
        drive(1'b1, 8'h5C, 1'b0, 1'b0);
        chk("t5_still_empty", 32'(el1), 32'd0);
        chk("t5_ft_valid", 32'(bus1.valid_o), 32'd1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_stored", 32'(el1), 32'd1);
        chk("t5_stored_data", 32'(bus1.data_o), 32'h5C);
        tick();

        // Asynchronous reset between edges with entries stored
        chk("t6_pre_elems", 32'(el0), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("t6_valid0", 32'(bus0.valid_o), 32'd0);
        chk("t6_elems0", 32'(el0), 32'd0);
        chk("t6_free0", 32'(fr0), 32'd3);
        chk("t6_ready0", 32'(bus0.ready_o), 32'd1);
        chk("t6_ovf0", 32'(ov0), 32'd0);
        chk("t6_elems1", 32'(el1), 32'd0);
        chk("t6_valid1", 32'(bus1.valid_o), 32'd0);
        mcnt[0] = 0; mcnt[1] = 0; movf[0] = 1'b0; movf[1] = 1'b0;
        #1 rst = 1'b0;

        // Randomised traffic in phases biased towards filling, draining and balance
        for (int n = 0; n < 3000; n++) begin
            int ph, pv, pr;
            ph = (n / 250) % 3;
            pv = (ph == 0) ? 80 : ((ph == 1) ? 30 : 55);
            pr = (ph == 0) ? 25 : ((ph == 1) ? 80 : 55);
            drive($urandom_range(99) < pv, 8'($urandom), $urandom_range(99) < pr,
                  $urandom_range(99) < 2);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_param_fifo.md
Name: io_param_fifo

Overview:
Parametrised successor to the generic IO FIFO used on peripheral data paths (UART/SPI/I2C streams to and from the bus side). Supports any depth ≥ 2, including non-power-of-two. Adds:
- an optional fall-through (zero-latency) mode,
- almost-full and almost-empty watermark outputs,
- a free-slot count,
- a sticky overflow flag for pushes attempted while full.

Parameters:
DATA_WIDTH, 32, width of data_i/data_o.
DEPTH, 4, number of storage entries; must be ≥ 2; need not be a power of two.
CNT_W, $clog2(DEPTH+1), width of the elements_o and free_o counts.
FALL_THROUGH, 0, when 1, data passes input to output combinationally while the FIFO is empty.
AFULL_LVL, DEPTH-1, almost_full_o asserts when elements ≥ AFULL_LVL; range 1..DEPTH.
AEMPTY_LVL, 1, almost_empty_o asserts when elements ≤ AEMPTY_LVL; range 0..DEPTH-1.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  asynchronous, active-high reset.
clr_i  in  1  synchronous flush; empties the FIFO and clears overflow_o.
valid_i  in  1  input side: data_i is valid.
data_i  in  DATA_WIDTH  input data.
ready_o  out  1  input side: FIFO accepts data this cycle.
valid_o  out  1  output side: data_o is valid.
data_o  out  DATA_WIDTH  output data (head of FIFO).
ready_i  in  1  output side: consumer takes data_o this cycle.
elements_o  out  CNT_W  number of stored entries.
free_o  out  CNT_W  DEPTH minus elements_o.
almost_full_o  out  1  watermark, as defined by AFULL_LVL.
almost_empty_o  out  1  watermark, as defined by AEMPTY_LVL.
overflow_o  out  1  sticky: a push was attempted while full.

Behaviour:
- Definitions:
  - push = valid_i & ready_o
  - pop = valid_o & ready_i
  - full = (elements == DEPTH)
  - empty = (elements == 0)
- Reset (rst_i high, asynchronous):
  - write pointer, read pointer and elements all go to 0; overflow_o goes to 0.
  - Storage array is not reset.
  - After reset, outputs are: valid_o=0, ready_o=1, elements_o=0, free_o=DEPTH, almost_empty_o=1, almost_full_o=0.
  - data_o is don't-care (FALL_THROUGH=0) or equals data_i (FALL_THROUGH=1).
- ready_o:
  - ready_o = ~full & ~clr_i.
  - Data presented while full is not stored.
- valid_o:
  - FALL_THROUGH=0: valid_o = ~empty & ~clr_i.
  - FALL_THROUGH=1: valid_o = (~empty | valid_i) & ~clr_i.
- data_o:
  - data_o = mem[rd_ptr] when not empty.
  - With FALL_THROUGH=1 and empty, data_o = data_i.
- Latency:
  - FALL_THROUGH=0: a pushed word appears on data_o the cycle after the push.
  - FALL_THROUGH=1: zero cycles when empty. Empty with push & pop in the same cycle means nothing is written and pointers and count are unchanged.
- Pointers:
  - Each pointer advances by 1 on its event and wraps from DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
  - Write on push unless it is a fall-through bypass; read on pop unless it is a bypass.
- Count update:
  - stored push without pop: +1
  - pop without push: -1
  - both: unchanged
  - neither: unchanged
  - Never exceeds DEPTH; never goes below 0.
- Full with push and pop requested: ready_o=0, so only the pop occurs and the count drops by 1. No same-cycle refill at full.
- Watermarks: almost_full_o and almost_empty_o are combinational compares on the registered count; they do not include the bypass word.
- Overflow: overflow_o sets on any cycle with valid_i & full & ~clr_i, and holds until clr_i or rst_i.
- clr_i priority:
  - Overrides push and pop in the same cycle.
  - Next cycle: pointers=0, elements=0, overflow_o=0.
  - During the clr_i cycle itself, valid_o=0 and ready_o=0.
- Mid-operation reset: state is lost immediately and asynchronously; no partial writes are committed.

Test Plan:
1. DATA_WIDTH=8, DEPTH=3, FALL_THROUGH=0, AFULL_LVL=2, AEMPTY_LVL=1. Push 0xA1, 0xA2, 0xA3 with ready_i=0.
   -> elements_o=1,2,3 after each push; almost_full_o=1 from elements=2; ready_o=0 at 3.
   -> Then pop with ready_i=1: data_o reads 0xA1, 0xA2, 0xA3 in order; valid_o=0 after the third pop.
2. Wrap with non-power-of-two depth: DEPTH=3, stream 10 words 0x00..0x09 with valid_i=ready_i=1 continuously.
   -> Output sequence is 0x00..0x09 in order, one cycle latency; elements_o stays at 1 throughout steady state.
3. Overflow: fill DEPTH=3, then hold valid_i=1 with 0xFF for 2 cycles, ready_i=0.
   -> overflow_o=1 from the next cycle and stays 1; contents remain unchanged.
   -> Assert clr_i for 1 cycle: elements_o=0, overflow_o=0, valid_o=0.
4. Full plus simultaneous request: full (3 entries), valid_i=1, ready_i=1 for 1 cycle.
   -> Head popped, new word not stored, elements_o=2; then a push on the next cycle is accepted.
5. FALL_THROUGH=1, empty, data_i=0x5C, valid_i=1, ready_i=1.
   -> Same cycle: valid_o=1, data_o=0x5C; elements_o stays 0.
   -> With ready_i=0 instead: the word is stored and elements_o=1.
6. Reset mid-operation: with 2 entries stored, pulse rst_i asynchronously between clock edges.
   -> Immediately: valid_o=0, elements_o=0, free_o=DEPTH, ready_o=1, overflow_o=0.
